cuenta_dir_param: RTL

CUENTA_DIR_PARAM -- requirements
Module: cuenta_dir_param

---
 rtl/cuenta_dir_param.sv | 75 +++++++
 1 files changed

// File: rtl/cuenta_dir_param.sv
// Up/down address counter: legal range MIN..MAX, rising-edge step requests, wrap or saturate.
// One cycle from a sampled event or load to qADD; no backpressure, a step is taken or dropped.
module cuenta_dir_param #(
   parameter int W    = 4,
   parameter int MIN  = 0,
   parameter int MAX  = 8,
   parameter int WRAP = 1
) (
   input  logic         clkADD,
   input  logic         resetADD,
   input  logic         enADD,
   input  logic         upADD,
   input  logic         downADD,
   input  logic         loadADD,
   input  logic [W-1:0] dinADD,
   output logic [W-1:0] qADD,
   output logic         wrapADD
);

   localparam logic [W-1:0] MIN_W = W'(MIN);
   localparam logic [W-1:0] MAX_W = W'(MAX);

   if (!((MIN >= 0) && (MIN < MAX) && (MAX <= (2 ** W) - 1))) begin : g_bad_params
      $error("cuenta_dir_param: illegal parameters, need 0 <= MIN < MAX <= 2^W-1");
   end

   logic up_hist;
   logic down_hist;
   logic up_ev;
   logic down_ev;
   logic din_ok;

   // History bits come out of reset at 1 so a request held across reset release is not an edge.
   assign up_ev   = upADD & ~up_hist;
   assign down_ev = downADD & ~down_hist;
   assign din_ok  = (dinADD >= MIN_W) && (dinADD <= MAX_W);

   always_ff @(posedge clkADD) begin
      if (resetADD) begin
         qADD      <= MIN_W;
         wrapADD   <= 1'b0;
         up_hist   <= 1'b1;
         down_hist <= 1'b1;
      end else begin
         up_hist   <= upADD;
         down_hist <= downADD;
         wrapADD   <= 1'b0;
         if (loadADD) begin
            qADD <= din_ok ? dinADD : MIN_W;
         end else if (enADD && (up_ev != down_ev)) begin
            if (up_ev) begin
               if (qADD >= MAX_W) begin
                  if (WRAP != 0) begin
                     qADD    <= MIN_W;
                     wrapADD <= 1'b1;
                  end
               end else begin
                  qADD <= qADD + 1'b1;
               end
            end else begin
               // Compare before subtracting so the count can never dip below MIN.
               if (qADD <= MIN_W) begin
                  if (WRAP != 0) begin
                     qADD    <= MAX_W;
                     wrapADD <= 1'b1;
                  end
               end else begin
                  qADD <= qADD - 1'b1;
               end
            end
         end
      end
   end

endmodule
